// File: rtl/matrix_register_bank.sv
// -----------------------------------------------------------------------------
// matrix_register_bank
//
// Register file holding NUM_MATRICES square matrices of SIZE x SIZE cells.
// One command per cycle: cell, row or column access with per-lane write
// masking, or a multi-cycle clear that zeroes one row of a matrix per cycle.
// Reads are registered (one cycle latency) and return pre-write data when a
// read and a write are issued together. Illegal commands leave storage
// untouched, pulse out_error and, if they carry a read, return zero data.
// -----------------------------------------------------------------------------
module matrix_register_bank #(
   parameter int SIZE          = 10,
   parameter int CELL_WIDTH    = 32,
   parameter int NUM_MATRICES  = 3,
   parameter int ADDRESS_WIDTH = $clog2(SIZE * SIZE),
   parameter int SEL_WIDTH     = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1
) (
   input  logic                           in_clk,
   input  logic                           in_reset,
   input  logic [ADDRESS_WIDTH-1:0]       in_address,
   input  logic [SIZE*CELL_WIDTH-1:0]     in_data,
   input  logic [1:0]                     in_type,
   input  logic [SEL_WIDTH-1:0]           in_select_matrix,
   input  logic                           in_read_en,
   input  logic                           in_write_en,
   input  logic [SIZE-1:0]                in_write_mask,
   output logic [SIZE*CELL_WIDTH-1:0]     out_data,
   output logic                           out_valid,
   output logic                           out_busy,
   output logic                           out_error
);

   // Width of a row or column index.
   localparam int IDX_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;

   // Bounds used for legality checks, one bit wider than the inputs so the
   // comparison works even when the bound itself is a power of two.
   localparam logic [ADDRESS_WIDTH:0]   NUM_CELLS = (ADDRESS_WIDTH + 1)'(SIZE * SIZE);
   localparam logic [SEL_WIDTH:0]       NUM_MATS  = (SEL_WIDTH + 1)'(NUM_MATRICES);
   localparam logic [ADDRESS_WIDTH-1:0] SIZE_A    = ADDRESS_WIDTH'(SIZE);
   localparam logic [IDX_WIDTH-1:0]     LAST_ROW  = IDX_WIDTH'(SIZE - 1);

   typedef enum logic [1:0] {
      ACC_CELL  = 2'b00,
      ACC_ROW   = 2'b01,
      ACC_COL   = 2'b10,
      ACC_CLEAR = 2'b11
   } access_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // -------------------------------------------------------------------------
   // Storage and state
   // -------------------------------------------------------------------------
   logic [CELL_WIDTH-1:0]     r_mem [NUM_MATRICES][SIZE][SIZE];

   state_e                    r_state;
   logic                      r_busy;
   logic [IDX_WIDTH-1:0]      r_clear_row;
   logic [SEL_WIDTH-1:0]      r_clear_sel;

   logic [SIZE*CELL_WIDTH-1:0] r_data;
   logic                      r_valid;
   logic                      r_error;

   // -------------------------------------------------------------------------
   // Command decode
   // -------------------------------------------------------------------------
   access_e                   w_type;
   logic [IDX_WIDTH-1:0]      w_row;
   logic [IDX_WIDTH-1:0]      w_col;
   logic                      w_addr_bad;
   logic                      w_sel_bad;
   logic                      w_illegal;
   logic                      w_accept;
   logic                      w_do_write;
   logic                      w_start_clear;
   logic [SIZE*CELL_WIDTH-1:0] w_read_data;

   assign w_type = access_e'(in_type);

   // Row and column are only meaningful for legal addresses; for illegal
   // ones the truncated values are never used to touch storage.
   assign w_row = IDX_WIDTH'(in_address / SIZE_A);
   assign w_col = IDX_WIDTH'(in_address % SIZE_A);

   assign w_addr_bad = ({1'b0, in_address} >= NUM_CELLS);
   assign w_sel_bad  = ({1'b0, in_select_matrix} >= NUM_MATS);
   assign w_illegal  = w_addr_bad || w_sel_bad || ((w_type == ACC_CLEAR) && in_read_en);

   // Commands arriving while a clear runs are dropped without any response.
   assign w_accept = !r_busy && (in_read_en || in_write_en);

   assign w_do_write    = w_accept && in_write_en && !w_illegal && (w_type != ACC_CLEAR);
   assign w_start_clear = w_accept && in_write_en && !w_illegal && (w_type == ACC_CLEAR);

   // Clear sequencer: walks the row counter over the selected matrix.
   always_ff @(posedge in_clk or negedge in_reset) begin
      // NOTE: state registers use non-blocking assignments so every block sees
      // the pre-edge values; blocking here would create order-dependent races.
      if (!in_reset) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_clear_row <= '0;
         r_clear_sel <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_clear) begin
                  r_state     <= ST_CLEAR;
                  r_busy      <= 1'b1;
                  r_clear_row <= '0;
                  r_clear_sel <= in_select_matrix;
               end
            end
            ST_CLEAR: begin
               if (r_clear_row == LAST_ROW) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_clear_row <= '0;
               end else begin
                  r_clear_row <= r_clear_row + IDX_WIDTH'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Storage update: clear rows while busy, otherwise apply accepted writes.
   always_ff @(posedge in_clk or negedge in_reset) begin
      // NOTE: the bank is built from flops, so it can and must be reset to zero;
      // a RAM macro would need an explicit clear sequence instead.
      if (!in_reset) begin
         for (int m = 0; m < NUM_MATRICES; m++) begin
            for (int r = 0; r < SIZE; r++) begin
               for (int c = 0; c < SIZE; c++) begin
                  r_mem[m][r][c] <= '0;
               end
            end
         end
      end else if (r_state == ST_CLEAR) begin
         for (int c = 0; c < SIZE; c++) begin
            r_mem[r_clear_sel][r_clear_row][c] <= '0;
         end
      end else if (w_do_write) begin
         case (w_type)
            ACC_CELL: begin
               r_mem[in_select_matrix][w_row][w_col] <= in_data[CELL_WIDTH-1:0];
            end
            ACC_ROW: begin
               for (int j = 0; j < SIZE; j++) begin
                  if (in_write_mask[j]) begin
                     r_mem[in_select_matrix][w_row][j] <= in_data[j*CELL_WIDTH +: CELL_WIDTH];
                  end
               end
            end
            ACC_COL: begin
               for (int j = 0; j < SIZE; j++) begin
                  if (in_write_mask[j]) begin
                     r_mem[in_select_matrix][j][w_col] <= in_data[j*CELL_WIDTH +: CELL_WIDTH];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Read multiplexer: gathers a cell, row or column from pre-write storage.
   always_comb begin
      // NOTE: the default assignment up front keeps every path driven, so no
      // latch is inferred for lanes or access types that are not selected.
      w_read_data = '0;
      if (!w_illegal) begin
         case (w_type)
            ACC_CELL: begin
               w_read_data[CELL_WIDTH-1:0] = r_mem[in_select_matrix][w_row][w_col];
            end
            ACC_ROW: begin
               for (int j = 0; j < SIZE; j++) begin
                  w_read_data[j*CELL_WIDTH +: CELL_WIDTH] = r_mem[in_select_matrix][w_row][j];
               end
            end
            ACC_COL: begin
               for (int j = 0; j < SIZE; j++) begin
                  w_read_data[j*CELL_WIDTH +: CELL_WIDTH] = r_mem[in_select_matrix][j][w_col];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered read port and error pulse.
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_valid <= w_accept && in_read_en;
         r_error <= w_accept && w_illegal;
         if (w_accept && in_read_en) begin
            r_data <= w_read_data;
         end
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_busy  = r_busy;
   assign out_error = r_error;

endmodule

// File: tb/tb_matrix_register_bank.sv
// -----------------------------------------------------------------------------
// tb_matrix_register_bank
//
// Bench for matrix_register_bank at SIZE=4, CELL_WIDTH=8, NUM_MATRICES=3.
// The address port is widened to 5 bits so out-of-range addresses exist.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed the command.
// -----------------------------------------------------------------------------
module tb_matrix_register_bank;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int NM = 3;

   logic        in_clk;
   logic        in_reset;
   logic [4:0]  in_address;
   logic [31:0] in_data;
   logic [1:0]  in_type;
   logic [1:0]  in_select_matrix;
   logic        in_read_en;
   logic        in_write_en;
   logic [3:0]  in_write_mask;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_busy;
   logic        out_error;

   matrix_register_bank #(
      .SIZE          (N),
      .CELL_WIDTH    (CW),
      .NUM_MATRICES  (NM),
      .ADDRESS_WIDTH (5),
      .SEL_WIDTH     (2)
   ) dut (
      .in_clk           (in_clk),
      .in_reset         (in_reset),
      .in_address       (in_address),
      .in_data          (in_data),
      .in_type          (in_type),
      .in_select_matrix (in_select_matrix),
      .in_read_en       (in_read_en),
      .in_write_en      (in_write_en),
      .in_write_mask    (in_write_mask),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_busy         (out_busy),
      .out_error        (out_error)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: plain 3-D array of cells plus a busy-cycle countdown.
   // A clear zeroes the whole matrix at once; its row-by-row progress is not
   // observable because every command is dropped while busy.
   // ---------------------------------------------------------------------------
   logic [7:0]  mm [NM][N][N];
   int          busy_left;
   logic [31:0] exp_data;
   bit          exp_valid;
   bit          exp_error;
   bit          exp_busy;

   task automatic model_reset();
      for (int m = 0; m < NM; m++)
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               mm[m][r][c] = 8'h00;
      busy_left = 0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_error = 1'b0;
      exp_busy  = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] typ, input int sel, input int addr);
      logic [31:0] res;
      int row;
      int col;
      res = '0;
      row = addr / N;
      col = addr % N;
      case (typ)
         2'b00: res[7:0] = mm[sel][row][col];
         2'b01: for (int j = 0; j < N; j++) res[j*CW +: CW] = mm[sel][row][j];
         2'b10: for (int j = 0; j < N; j++) res[j*CW +: CW] = mm[sel][j][col];
         default: res = '0;
      endcase
      return res;
   endfunction

   // Drive one command at a falling edge, predict the outcome, and advance to
   // the next falling edge where the outputs reflect that command.
   task automatic step(input logic [1:0] typ, input int sel, input int addr,
                       input bit rd, input bit wr, input logic [31:0] data,
                       input logic [3:0] mask);
      bit acc;
      bit ill;
      int row;
      int col;
      in_type          = typ;
      in_select_matrix = 2'(sel);
      in_address       = 5'(addr);
      in_read_en       = rd;
      in_write_en      = wr;
      in_data          = data;
      in_write_mask    = mask;

      acc = (busy_left == 0) && (rd || wr);
      ill = (addr >= N*N) || (sel >= NM) || ((typ == 2'b11) && rd);
      if (acc && rd) exp_data = ill ? 32'h0 : model_read(typ, sel, addr);
      exp_valid = acc && rd;
      exp_error = acc && ill;
      if (busy_left > 0) busy_left--;
      if (acc && !ill && wr) begin
         row = addr / N;
         col = addr % N;
         case (typ)
            2'b00: mm[sel][row][col] = data[7:0];
            2'b01: for (int j = 0; j < N; j++) if (mask[j]) mm[sel][row][j] = data[j*CW +: CW];
            2'b10: for (int j = 0; j < N; j++) if (mask[j]) mm[sel][j][col] = data[j*CW +: CW];
            default: begin
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++)
                     mm[sel][r][c] = 8'h00;
               busy_left = N;
            end
         endcase
      end
      exp_busy = (busy_left > 0);

      @(posedge in_clk);
      @(negedge in_clk);
   endtask

   task automatic idle();
      step(2'b00, 0, 0, 1'b0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic check_model(input string tag);
      check($sformatf("%s.data", tag),  out_data, exp_data);
      check($sformatf("%s.valid", tag), 32'(out_valid), 32'(exp_valid));
      check($sformatf("%s.error", tag), 32'(out_error), 32'(exp_error));
      check($sformatf("%s.busy", tag),  32'(out_busy),  32'(exp_busy));
   endtask

   // ---------------------------------------------------------------------------
   // Directed vectors with literal expectations
   // ---------------------------------------------------------------------------
   typedef struct {
      string       name;
      logic [1:0]  typ;
      int          sel;
      int          addr;
      bit          rd;
      bit          wr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] e_data;
      bit          e_valid;
      bit          e_error;
   } vec_t;

   vec_t vecs [17];

   initial begin
      vecs[0]  = '{"rst_rd_m1r2",   2'b01, 1,  8, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1, 1'b0};
      vecs[1]  = '{"wr_m0_row1",    2'b01, 0,  4, 1'b0, 1'b1, 32'h44332211, 4'hF, 32'h00000000, 1'b0, 1'b0};
      vecs[2]  = '{"rd_row_a4",     2'b01, 0,  4, 1'b1, 1'b0, 32'h0,        4'h0, 32'h44332211, 1'b1, 1'b0};
      vecs[3]  = '{"rd_cell_a6",    2'b00, 0,  6, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00000033, 1'b1, 1'b0};
      vecs[4]  = '{"rd_col_a2",     2'b10, 0,  2, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00003300, 1'b1, 1'b0};
      vecs[5]  = '{"wr_m2_col3_msk",2'b10, 2,  3, 1'b0, 1'b1, 32'hDDCCBBAA, 4'h5, 32'h00003300, 1'b0, 1'b0};
      vecs[6]  = '{"rd_m2_col3",    2'b10, 2,  3, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00CC00AA, 1'b1, 1'b0};
      vecs[7]  = '{"rw_same_row",   2'b01, 0,  4, 1'b1, 1'b1, 32'h55555555, 4'hF, 32'h44332211, 1'b1, 1'b0};
      vecs[8]  = '{"rd_after_rw",   2'b01, 0,  4, 1'b1, 1'b0, 32'h0,        4'h0, 32'h55555555, 1'b1, 1'b0};
      vecs[9]  = '{"ill_addr16",    2'b00, 0, 16, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1, 1'b1};
      vecs[10] = '{"ill_sel3_rd",   2'b01, 3,  0, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1, 1'b1};
      vecs[11] = '{"ill_sel3_wr",   2'b01, 3,  0, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0, 1'b1};
      vecs[12] = '{"ill_clr_rd",    2'b11, 2,  0, 1'b1, 1'b1, 32'h0,        4'h0, 32'h00000000, 1'b1, 1'b1};
      vecs[13] = '{"rd_m2_col3_b",  2'b10, 2,  3, 1'b1, 1'b0, 32'h0,        4'h0, 32'h00CC00AA, 1'b1, 1'b0};
      vecs[14] = '{"wr_m1_cell15",  2'b00, 1, 15, 1'b0, 1'b1, 32'hFFFFFF5A, 4'h0, 32'h00CC00AA, 1'b0, 1'b0};
      vecs[15] = '{"rd_m1_cell15",  2'b00, 1, 15, 1'b1, 1'b0, 32'h0,        4'h0, 32'h0000005A, 1'b1, 1'b0};
      vecs[16] = '{"idle_hold",     2'b00, 0,  0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0000005A, 1'b0, 1'b0};
   end

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int busy_cnt;
      in_reset         = 1'b0;
      in_address       = '0;
      in_data          = '0;
      in_type          = '0;
      in_select_matrix = '0;
      in_read_en       = 1'b0;
      in_write_en      = 1'b0;
      in_write_mask    = '0;
      model_reset();

      // Reset state
      @(negedge in_clk);
      @(negedge in_clk);
      check("rst.data",  out_data, 32'h0);
      check("rst.valid", 32'(out_valid), 32'h0);
      check("rst.busy",  32'(out_busy),  32'h0);
      check("rst.error", 32'(out_error), 32'h0);
      in_reset = 1'b1;

      // Directed table
      for (int i = 0; i < 17; i++) begin
         step(vecs[i].typ, vecs[i].sel, vecs[i].addr, vecs[i].rd, vecs[i].wr,
              vecs[i].data, vecs[i].mask);
         check($sformatf("%s.data", vecs[i].name),  out_data, vecs[i].e_data);
         check($sformatf("%s.valid", vecs[i].name), 32'(out_valid), 32'(vecs[i].e_valid));
         check($sformatf("%s.error", vecs[i].name), 32'(out_error), 32'(vecs[i].e_error));
      end

      // Clear of matrix 0: busy for exactly N cycles, commands dropped meanwhile
      step(2'b11, 0, 0, 1'b0, 1'b1, 32'h0, 4'h0);
      check("clr.start_busy", 32'(out_busy), 32'h1);
      busy_cnt = out_busy ? 1 : 0;
      step(2'b00, 0, 0, 1'b0, 1'b1, 32'h00000077, 4'hF);
      check("clr.drop_wr_err", 32'(out_error), 32'h0);
      if (out_busy) busy_cnt++;
      step(2'b01, 1, 12, 1'b1, 1'b0, 32'h0, 4'h0);
      check("clr.drop_rd_valid", 32'(out_valid), 32'h0);
      check("clr.drop_rd_err",   32'(out_error), 32'h0);
      if (out_busy) busy_cnt++;
      for (int k = 0; k < 6; k++) begin
         idle();
         if (out_busy) busy_cnt++;
      end
      check("clr.busy_cycles", 32'(busy_cnt), 32'd4);
      for (int r = 0; r < N; r++) begin
         step(2'b01, 0, r * N, 1'b1, 1'b0, 32'h0, 4'h0);
         check($sformatf("clr.m0_row%0d", r), out_data, 32'h0);
         check($sformatf("clr.m0_row%0d.valid", r), 32'(out_valid), 32'h1);
      end
      step(2'b10, 2, 3, 1'b1, 1'b0, 32'h0, 4'h0);
      check("clr.m2_col3_kept", out_data, 32'h00CC00AA);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [1:0] typ;
         int sel;
         int addr;
         typ  = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         sel  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
         step(typ, sel, addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom), 4'($urandom));
         check_model($sformatf("rnd%0d", i));
      end

      // Make sure matrix 1 holds something, then reset in cycle 2 of a clear
      for (int k = 0; k < 8; k++) idle();
      step(2'b01, 1, 4, 1'b0, 1'b1, 32'hA5A5A5A5, 4'hF);
      step(2'b11, 1, 0, 1'b0, 1'b1, 32'h0, 4'h0);
      idle();
      check("rstclr.busy_before", 32'(out_busy), 32'h1);
      #2;
      in_reset = 1'b0;
      #1;
      check("rstclr.busy_now",  32'(out_busy),  32'h0);
      check("rstclr.valid_now", 32'(out_valid), 32'h0);
      check("rstclr.data_now",  out_data,       32'h0);
      model_reset();
      @(negedge in_clk);
      in_reset = 1'b1;
      for (int m = 0; m < NM; m++) begin
         for (int r = 0; r < N; r++) begin
            step(2'b01, m, r * N, 1'b1, 1'b0, 32'h0, 4'h0);
            check($sformatf("rstclr.m%0d_row%0d", m, r), out_data, 32'h0);
            check($sformatf("rstclr.m%0d_row%0d.valid", m, r), 32'(out_valid), 32'h1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matrix_register_bank.md
Name: matrix_register_bank

Overview:
- Parametrised successor to the coprocessor matrix register file.
- Holds NUM_MATRICES square matrices of SIZE x SIZE cells, each CELL_WIDTH bits wide.
- Supports cell, row and column access with per-lane write masking, a registered read port with a valid flag, and a multi-cycle matrix-clear operation.
- Sits between the coprocessor controller and the matrix ALU; a full row or column moves in one beat.

Parameters:
- SIZE, 10, matrix dimension (rows = columns).
- CELL_WIDTH, 32, bits per cell.
- NUM_MATRICES, 3, number of matrices (A=0, B=1, C=2, ...).
- ADDRESS_WIDTH, $clog2(SIZE*SIZE), linear cell address width.
- SEL_WIDTH, max(1,$clog2(NUM_MATRICES)), matrix select width.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_address  input  ADDRESS_WIDTH  linear address = row*SIZE + col.
- in_data  input  SIZE*CELL_WIDTH  write data; lane j = bits [j*CELL_WIDTH +: CELL_WIDTH].
- in_type  input  2  access type: 00 cell, 01 row, 10 column, 11 clear matrix.
- in_select_matrix  input  SEL_WIDTH  target matrix.
- in_read_en  input  1  read request.
- in_write_en  input  1  write request; for type 11 this starts a clear.
- in_write_mask  input  SIZE  per-lane write enable for row and column writes.
- out_data  output  SIZE*CELL_WIDTH  registered read data.
- out_valid  output  1  out_data holds the result of the previous cycle's accepted read.
- out_busy  output  1  clear in progress; commands are ignored while high.
- out_error  output  1  one-cycle pulse when an accepted command is illegal.

Behaviour:
- Reset (in_reset=0, asynchronous):
  - All cells = 0.
  - out_data = 0, out_valid = 0, out_busy = 0, out_error = 0.
  - FSM = IDLE; clear row counter = 0.
  - Reset mid-clear aborts the clear; the result is still all-zero storage.
- Address decode: row = in_address / SIZE, col = in_address % SIZE.
  - Row access uses only row; column access uses only col.
- Accepting a command: a command is accepted only when out_busy = 0 and in_read_en or in_write_en is 1.
- Illegal command, any of:
  - in_address >= SIZE*SIZE;
  - in_select_matrix >= NUM_MATRICES;
  - type 11 with in_read_en = 1.
- On an illegal command:
  - out_error pulses for 1 cycle.
  - Storage is unchanged.
  - A read still produces out_valid with out_data = 0.
- Cell write (00): lane 0 of in_data goes to cell [row][col]. in_write_mask is ignored.
- Row write (01): lane j goes to [row][j] for each j with in_write_mask[j] = 1.
- Column write (10): lane j goes to [j][col] for each j with in_write_mask[j] = 1.
- Reads, latency 1 cycle (out_data and out_valid update on the edge after acceptance):
  - Cell: out_data lane 0 = cell, all other lanes 0.
  - Row: lane j = [row][j].
  - Column: lane j = [j][col].
- out_valid is 1 for exactly the cycle following each accepted read, else 0. out_data holds its last value when no read occurs.
- Read and write in the same cycle:
  - Both are performed.
  - The read returns pre-write data (read-before-write), even when the addresses overlap.
- Clear (11 with write_en):
  - FSM goes IDLE -> CLEAR.
  - Row r of the selected matrix is zeroed on the r-th cycle of CLEAR.
  - The row counter runs 0..SIZE-1, then returns to IDLE.
  - out_busy is high for exactly SIZE cycles, starting the cycle after acceptance.
  - Commands during busy are dropped silently: no error, no valid.
- Other matrices remain readable only after busy drops; there is no concurrent access.

Test Plan (SIZE=4, CELL_WIDTH=8, NUM_MATRICES=3):
- Reset:
  - Release reset, then row-read matrix 1 row 2 -> out_valid=1 one cycle later, out_data=32'h00000000.
- Row write then reads:
  - Write row 1 of matrix 0 with in_data=32'h44332211, mask=4'hF.
  - Row read addr 4 -> 32'h44332211.
  - Cell read addr 6 -> 32'h00000033.
  - Column read addr 2 -> 32'h00003300.
- Masked column write:
  - Write column 3 of matrix 2 with in_data=32'hDDCCBBAA, mask=4'b0101.
  - Column read addr 3 -> 32'h00CC00AA.
- Same-cycle read and write:
  - Read and write row 1 of matrix 0 together with new data 32'h55555555 -> out_data=32'h44332211.
  - Next read -> 32'h55555555.
- Clear:
  - Clear matrix 0 -> out_busy high exactly 4 cycles.
  - A write issued during busy is dropped.
  - Afterwards all rows read 0; matrix 2 column 3 is still 32'h00CC00AA.
- Illegal commands and reset mid-clear:
  - Address 16 -> out_error pulse, read returns 0.
  - in_select_matrix=3 -> out_error pulse.
  - Assert reset on cycle 2 of a clear -> out_busy=0 immediately; all matrices read 0.
